// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: holds the pipeline for a fixed number of wait
// states, merges byte/half stores into lane-wide memory and extends loaded data.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        access_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, wdata_reg, hold_reg;
    logic [2:0]  funct3_reg;
    logic        store_reg;

    logic          req, accept, exec;
    logic [31:0]   op_addr, op_wdata;
    logic [2:0]    op_f3;
    logic          op_store, op_fault, resp_fault;
    logic [AW-1:0] op_idx;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data, rword, shifted, load_val;
    logic          unused_ok;

    function automatic logic is_fault(input logic st, input logic [2:0] f, input logic [1:0] lo);
        case (f)
            3'b000:  is_fault = 1'b0;
            3'b001:  is_fault = lo[0];
            3'b010:  is_fault = |lo;
            3'b100:  is_fault = st;
            3'b101:  is_fault = st | lo[0];
            default: is_fault = 1'b1;
        endcase
    endfunction

    assign req = rst_n & (mem_read | mem_write);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        accept     = 1'b0;
        exec       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall    = 1'b1;
                    accept   = 1'b1;
                    cnt_next = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        exec       = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    exec       = 1'b1;
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access executes on the accept edge, so the
    // operands come straight from the ports instead of the latched copies.
    assign op_addr  = (state_reg == IDLE) ? addr      : addr_reg;
    assign op_wdata = (state_reg == IDLE) ? wdata     : wdata_reg;
    assign op_f3    = (state_reg == IDLE) ? funct3    : funct3_reg;
    assign op_store = (state_reg == IDLE) ? mem_write : store_reg;
    assign op_idx   = op_addr[AW+1:2];
    assign op_fault = is_fault(op_store, op_f3, op_addr[1:0]);
    assign unused_ok = &{1'b0, op_addr[31:AW+2]};

    always_comb begin
        lane_en   = 4'b1111;
        lane_data = op_wdata;
        case (op_f3[1:0])
            2'b00: begin
                lane_en   = 4'b0001 << op_addr[1:0];
                lane_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = op_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // One byte-wide bank per lane keeps each lane's write strobe independent.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] bank [DEPTH_WORDS];
        logic [7:0] rbyte_reg;
        always_ff @(posedge clk) begin
            if (exec && op_store && !op_fault && lane_en[gi])
                bank[op_idx] <= lane_data[gi*8 +: 8];
            if (exec && !op_store)
                rbyte_reg <= bank[op_idx];
        end
        assign rword[gi*8 +: 8] = rbyte_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            funct3_reg <= '0;
            store_reg  <= 1'b0;
            hold_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg   <= addr;
                wdata_reg  <= wdata;
                funct3_reg <= funct3;
                store_reg  <= mem_write;
            end
            if (done && !store_reg)
                hold_reg <= load_val;
        end
    end

    assign resp_fault = is_fault(store_reg, funct3_reg, addr_reg[1:0]);
    assign shifted    = rword >> {addr_reg[1:0], 3'b000};

    always_comb begin
        case (funct3_reg)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = rword;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = '0;
        endcase
        if (resp_fault)
            load_val = '0;
    end

    assign done         = (state_reg == RESP);
    assign access_fault = done & resp_fault;
    assign rdata        = (done && !store_reg) ? load_val : hold_reg;
endmodule
